// File: rtl/nn_vote_classifier.sv
// rtl/nn_vote_classifier.sv - windowed hit-count vote over an 8-output activation vector
// Counts per-output hits over WINDOW samples, then resolves the argmax with a sequential scan.
module nn_vote_classifier #(
  parameter int WINDOW = 16,
  parameter int CNT_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic [7:0]       act_in,
  input  logic             act_valid,
  output logic             busy,
  output logic             result_valid,
  output logic [2:0]       class_idx,
  output logic [CNT_W-1:0] class_cnt,
  output logic             tie
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_RESOLVE, S_DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(WINDOW - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q [8];
  logic [CNT_W-1:0] cnt_d [8];
  logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
  logic [3:0]       scan_idx_q, scan_idx_d;
  logic [CNT_W-1:0] best_q, best_d;
  logic [2:0]       best_idx_q, best_idx_d;
  logic             tie_r_q, tie_r_d;
  logic [2:0]       class_idx_q, class_idx_d;
  logic [CNT_W-1:0] class_cnt_q, class_cnt_d;
  logic             tie_q, tie_d;
  logic [CNT_W-1:0] cur_cnt;

  assign cur_cnt = cnt_q[scan_idx_q[2:0]];

  always_comb begin
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    scan_idx_d   = scan_idx_q;
    best_d       = best_q;
    best_idx_d   = best_idx_q;
    tie_r_d      = tie_r_q;
    class_idx_d  = class_idx_q;
    class_cnt_d  = class_cnt_q;
    tie_d        = tie_q;
    for (int i = 0; i < 8; i++) cnt_d[i] = cnt_q[i];

    if (ena) begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            for (int i = 0; i < 8; i++) cnt_d[i] = '0;
            sample_cnt_d = '0;
            state_d      = S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (act_valid) begin
            for (int i = 0; i < 8; i++) begin
              if (act_in[i] && cnt_q[i] != CNT_MAX) cnt_d[i] = cnt_q[i] + 1'b1;
            end
            sample_cnt_d = sample_cnt_q + 1'b1;
            if (sample_cnt_q == LAST_SAMPLE) begin
              state_d    = S_RESOLVE;
              scan_idx_d = '0;
            end
          end
        end
        S_RESOLVE: begin
          // idx 0..7 compare one counter each; idx 8 publishes the settled best regs.
          if (scan_idx_q[3]) begin
            class_idx_d = best_idx_q;
            class_cnt_d = best_q;
            tie_d       = tie_r_q;
            state_d     = S_DONE;
          end else begin
            if (scan_idx_q == 4'd0) begin
              best_d     = cur_cnt;
              best_idx_d = 3'd0;
              tie_r_d    = 1'b0;
            end else if (cur_cnt > best_q) begin
              best_d     = cur_cnt;
              best_idx_d = scan_idx_q[2:0];
              tie_r_d    = 1'b0;
            end else if (cur_cnt == best_q) begin
              tie_r_d = 1'b1;
            end
            scan_idx_d = scan_idx_q + 4'd1;
          end
        end
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      sample_cnt_q <= '0;
      scan_idx_q   <= '0;
      best_q       <= '0;
      best_idx_q   <= '0;
      tie_r_q      <= 1'b0;
      class_idx_q  <= '0;
      class_cnt_q  <= '0;
      tie_q        <= 1'b0;
      for (int i = 0; i < 8; i++) cnt_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      sample_cnt_q <= sample_cnt_d;
      scan_idx_q   <= scan_idx_d;
      best_q       <= best_d;
      best_idx_q   <= best_idx_d;
      tie_r_q      <= tie_r_d;
      class_idx_q  <= class_idx_d;
      class_cnt_q  <= class_cnt_d;
      tie_q        <= tie_d;
      for (int i = 0; i < 8; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign result_valid = (state_q == S_DONE);
  assign class_idx    = class_idx_q;
  assign class_cnt    = class_cnt_q;
  assign tie          = tie_q;

endmodule

// File: tb/tb_nn_vote_classifier.sv
// tb/tb_nn_vote_classifier.sv - scoreboard bench for nn_vote_classifier
// Stimulus pushes expected results; a negedge monitor pops them on each result pulse.
module tb_nn_vote_classifier;

  localparam int WINDOW = 16;
  localparam int CNT_W  = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ena = 1'b0;
  logic             start = 1'b0;
  logic [7:0]       act_in = '0;
  logic             act_valid = 1'b0;
  logic             busy;
  logic             result_valid;
  logic [2:0]       class_idx;
  logic [CNT_W-1:0] class_cnt;
  logic             tie;

  nn_vote_classifier #(.WINDOW(WINDOW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .act_in(act_in),
    .act_valid(act_valid), .busy(busy), .result_valid(result_valid),
    .class_idx(class_idx), .class_cnt(class_cnt), .tie(tie)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int cnt;
    int tie;
    int due;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && result_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected result_valid", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("class_idx", int'(class_idx), e.idx);
        check("class_cnt", int'(class_cnt), e.cnt);
        check("tie", int'(tie), e.tie);
        check("result latency", cyc, e.due);
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    ena = 1'b1; act_valid = 1'b0; start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic sample(input logic [7:0] a);
    act_in = a; act_valid = 1'b1;
    cycle();
    act_valid = 1'b0;
  endtask

  task automatic window_uniform(input logic [7:0] a);
    for (int i = 0; i < WINDOW; i++) sample(a);
  endtask

  task automatic expect_result(input int idx, input int cnt, input int t, input int stalls);
    exp_t e;
    e.idx = idx; e.cnt = cnt; e.tie = t; e.due = cyc + 9 + stalls;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 40) begin
      cycle();
      k++;
    end
    if (exp_q.size() != 0) begin
      check("result timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    cycle();
    check("reset busy", busy, 0);
    check("reset result_valid", result_valid, 0);
    check("reset class_idx", class_idx, 0);
    check("reset class_cnt", class_cnt, 0);
    check("reset tie", tie, 0);

    // 1: single hot output
    do_start();
    check("busy in ACCUM", busy, 1);
    window_uniform(8'h04);
    expect_result(2, 16, 0, 0);
    drain();

    // 2: two outputs tied at full count
    do_start();
    window_uniform(8'h81);
    expect_result(0, 16, 1, 0);
    drain();

    // 3: all-zero window
    do_start();
    window_uniform(8'h00);
    expect_result(0, 0, 1, 0);
    drain();
    check("busy after DONE", busy, 0);

    // Later higher count displaces earlier best and clears tie
    do_start();
    for (int i = 0; i < 10; i++) sample(8'h80);
    for (int i = 0; i < 6; i++) sample(8'h48);
    expect_result(7, 10, 0, 0);
    drain();

    // Mixed counts: output 1 beats output 0
    do_start();
    for (int i = 0; i < 8; i++) begin
      sample(8'h03);
      sample(8'h02);
    end
    expect_result(1, 16, 0, 0);
    drain();

    // 4: gaps and stalls in ACCUM, three stalls inside RESOLVE
    do_start();
    for (int i = 0; i < WINDOW; i++) begin
      if (i % 3 == 1) begin
        act_valid = 1'b0; act_in = 8'hFF;
        cycle();
      end
      if (i % 4 == 2) begin
        ena = 1'b0; act_valid = 1'b1; act_in = 8'hFF; start = 1'b1;
        cycle();
        ena = 1'b1; act_valid = 1'b0; start = 1'b0;
      end
      sample(8'h40);
    end
    expect_result(6, 16, 0, 3);
    cycle();
    ena = 1'b0; act_valid = 1'b1; act_in = 8'hFF; start = 1'b1;
    repeat (3) cycle();
    ena = 1'b1; act_valid = 1'b0; start = 1'b0;
    drain();
    check("class_idx holds", class_idx, 6);

    // 5: start ignored outside IDLE; DONE start ignored, next IDLE start accepted
    do_start();
    for (int i = 0; i < WINDOW; i++) begin
      start = (i == 5 || i == 11);
      sample(8'h10);
    end
    start = 1'b0;
    expect_result(4, 16, 0, 0);
    for (int k = 1; k <= 9; k++) begin
      start = k[0];
      cycle();
    end
    start = 1'b1;
    cycle();
    check("start in DONE ignored", busy, 0);
    start = 1'b1;
    cycle();
    start = 1'b0;
    check("start in IDLE accepted", busy, 1);
    window_uniform(8'h22);
    expect_result(1, 16, 1, 0);
    drain();

    // 6: async reset mid-window
    do_start();
    for (int i = 0; i < 7; i++) sample(8'h08);
    #3 rst_n = 1'b0;
    #1;
    check("async reset busy", busy, 0);
    check("async reset result_valid", result_valid, 0);
    check("async reset class_idx", class_idx, 0);
    check("async reset class_cnt", class_cnt, 0);
    check("async reset tie", tie, 0);
    @(negedge clk) rst_n = 1'b1;
    cycle();
    for (int i = 0; i < 20; i++) sample(8'h08);
    check("no window without start", busy, 0);
    do_start();
    window_uniform(8'h20);
    expect_result(5, 16, 0, 0);
    drain();

    repeat (15) cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
